// File: rtl/dac_ddr_pkg.sv
// Shared constants for the DDR DAC output stage: mode codes, FSM states, mid-scale helper.
package dac_ddr_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_MUTE   = 2'd1,
        MODE_RAMP   = 2'd2,
        MODE_CONST  = 2'd3
    } mode_e;

    typedef enum logic {
        ST_WARM = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Offset-binary zero for a dw-bit word (1 << (dw-1)); caller truncates to dw bits.
    function automatic logic [31:0] midscale(input int unsigned dw);
        return 32'd1 << (dw - 1);
    endfunction

endpackage

// File: rtl/dac_ddr_out_if.sv
// Sample/control bus between the DSP chain and the DAC output stage.
//  master: drives data0/data1/dc_offset/mode/mode_stb/pattern, observes status and pins.
//  slave : the output stage; drives ready/sat/q0_mon/q1_mon/dacp/dacn.
interface dac_ddr_out_if #(
    parameter int unsigned DW = 14
);
    logic [DW-1:0] data0;
    logic [DW-1:0] data1;
    logic [DW-1:0] dc_offset;
    logic [1:0]    mode;
    logic          mode_stb;
    logic [DW-1:0] pattern;
    logic          ready;
    logic          sat;
    logic [DW-1:0] q0_mon;
    logic [DW-1:0] q1_mon;
    logic [DW-1:0] dacp;
    logic [DW-1:0] dacn;

    modport master (
        output data0, data1, dc_offset, mode, mode_stb, pattern,
        input  ready, sat, q0_mon, q1_mon, dacp, dacn
    );

    modport slave (
        input  data0, data1, dc_offset, mode, mode_stb, pattern,
        output ready, sat, q0_mon, q1_mon, dacp, dacn
    );
endinterface

// File: rtl/dac_ddr_cell.sv
// One DAC pin pair: behavioural SAME_EDGE DDR register (both halves captured on the
// rising edge, d1 driven while clk is high, d2 while low) followed by a differential buffer.
//  clk   : DDR clock
//  d1/d2 : rising-half / falling-half data
//  pad_p/pad_n : differential output pair
module dac_ddr_cell (
    input  logic clk,
    input  logic d1,
    input  logic d2,
    output logic pad_p,
    output logic pad_n
);
    logic d1_r;
    logic d2_r;
    logic q;

    // Set/reset are tied off; the stage relies on its inputs being mid-scale during reset.
    always_ff @(posedge clk) begin
        d1_r <= d1;
        d2_r <= d2;
    end

    assign q     = clk ? d1_r : d2_r;
    assign pad_p = q;
    assign pad_n = ~q;
endmodule

// File: rtl/dac_ddr_out.sv
// DDR output stage for an offset-binary LVDS DAC: DC offset with saturation, mode mux
// (normal/mute/ramp/const), post-reset warm-up hold, and per-bit DDR pin cells.
//  clk : sample-pair clock      rst : async active-high reset
//  bus : dac_ddr_out_if.slave (samples, offset, mode/strobe, pattern in;
//        ready, sticky sat, q0_mon/q1_mon taps, dacp/dacn pins out)
module dac_ddr_out
    import dac_ddr_pkg::*;
#(
    parameter int unsigned DW        = 14,
    parameter bit          TWOS_COMP = 1'b1,
    parameter int unsigned WARMUP    = 16,
    parameter int unsigned RAMP_STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    dac_ddr_out_if.slave bus
);
    localparam int unsigned   CW      = $clog2(WARMUP + 1);
    localparam logic [DW-1:0] MID     = DW'(midscale(DW));
    // Internally everything is two's complement; offset-binary inputs get their MSB flipped.
    localparam logic [DW-1:0] IN_FLIP = TWOS_COMP ? '0 : MID;
    localparam logic [DW-1:0] STEP    = DW'(RAMP_STEP);
    localparam logic [DW-1:0] STEP2   = DW'(2 * RAMP_STEP);

    state_e        state, state_nxt;
    logic [CW-1:0] warm_cnt, warm_cnt_nxt;
    logic          ready_r, ready_nxt;
    mode_e         mode_r, eff_mode;
    logic [DW-1:0] s1_0, s1_1;
    logic [DW:0]   c0, c1;
    logic          sat_r, sat_nxt;
    logic [DW-1:0] ramp_r, ramp_nxt;
    logic [DW-1:0] w0, w1;
    logic [DW-1:0] q0_r, q1_r;

    // Signed add in DW+1 bits, clamp to DW-bit range; returns {saturated, value}.
    function automatic logic [DW:0] add_clamp(input logic [DW-1:0] d, input logic [DW-1:0] off);
        logic [DW:0] s;
        s = {d[DW-1], d} + {off[DW-1], off};
        if (s[DW] != s[DW-1]) begin
            return {1'b1, s[DW], {(DW-1){~s[DW]}}};
        end
        return {1'b0, s[DW-1:0]};
    endfunction

    // Warm-up FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_WARM;
            warm_cnt <= '0;
            ready_r  <= 1'b0;
        end else begin
            state    <= state_nxt;
            warm_cnt <= warm_cnt_nxt;
            ready_r  <= ready_nxt;
        end
    end

    // Warm-up FSM next state: RUN and ready on the edge the counter reaches WARMUP.
    always_comb begin
        state_nxt    = state;
        warm_cnt_nxt = warm_cnt;
        case (state)
            ST_WARM: begin
                if (warm_cnt == CW'(WARMUP - 1)) begin
                    state_nxt    = ST_RUN;
                    warm_cnt_nxt = CW'(WARMUP);
                end else begin
                    warm_cnt_nxt = warm_cnt + CW'(1);
                end
            end
            ST_RUN:  ;
            default: state_nxt = ST_WARM;
        endcase
        ready_nxt = (state_nxt == ST_RUN);
    end

    // Warm-up overrides the latched mode with mute.
    assign eff_mode = (state == ST_RUN) ? mode_r : MODE_MUTE;

    assign c0 = add_clamp(bus.data0 ^ IN_FLIP, bus.dc_offset ^ IN_FLIP);
    assign c1 = add_clamp(bus.data1 ^ IN_FLIP, bus.dc_offset ^ IN_FLIP);

    // A saturation in the strobe cycle beats the clear.
    assign sat_nxt  = (bus.mode_stb ? 1'b0 : sat_r) | c0[DW] | c1[DW];
    assign ramp_nxt = (eff_mode == MODE_RAMP) ? ramp_r + STEP2 : '0;

    // S2 mode mux, two's complement domain.
    always_comb begin
        w0 = '0;
        w1 = '0;
        case (eff_mode)
            MODE_NORMAL: begin
                w0 = s1_0;
                w1 = s1_1;
            end
            MODE_RAMP: begin
                w0 = ramp_r;
                w1 = ramp_r + STEP;
            end
            MODE_CONST: begin
                w0 = bus.pattern ^ IN_FLIP;
                w1 = bus.pattern ^ IN_FLIP;
            end
            default: ;
        endcase
    end

    // Mode latch, S1 clamp stage, ramp counter and S2 offset-binary output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r <= MODE_MUTE;
            s1_0   <= '0;
            s1_1   <= '0;
            sat_r  <= 1'b0;
            ramp_r <= '0;
            q0_r   <= MID;
            q1_r   <= MID;
        end else begin
            if (bus.mode_stb) begin
                mode_r <= mode_e'(bus.mode);
            end
            s1_0   <= c0[DW-1:0];
            s1_1   <= c1[DW-1:0];
            sat_r  <= sat_nxt;
            ramp_r <= ramp_nxt;
            q0_r   <= w0 ^ MID;
            q1_r   <= w1 ^ MID;
        end
    end

    assign bus.ready  = ready_r;
    assign bus.sat    = sat_r;
    assign bus.q0_mon = q0_r;
    assign bus.q1_mon = q1_r;

    for (genvar i = 0; i < DW; i++) begin : g_cell
        dac_ddr_cell u_cell (
            .clk   (clk),
            .d1    (q0_r[i]),
            .d2    (q1_r[i]),
            .pad_p (bus.dacp[i]),
            .pad_n (bus.dacn[i])
        );
    end
endmodule
